// File: rtl/feature_map_writer_pkg.sv
// feature_map_writer_pkg: shared state encoding and output-map geometry helpers
package feature_map_writer_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ACCEPT = 2'd1, DONE = 2'd2} state_e;
    function automatic int out_dim(input int n, input int f);
        return n - f + 1;
    endfunction
    // Element index of the first pixel of a half-row; also used by the selector side
    function automatic int elem_offset(input int row, input int col, input int out_w);
        return row * out_w + col * (out_w / 2);
    endfunction
endpackage

// File: rtl/feature_map_writer_rf_pos_counter.sv
// rf_pos_counter: row/half-column position walker shared by writer and selector sequencer
module rf_pos_counter #(
    parameter int ROWS = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear_i,
    input  logic       advance_i,
    output logic [3:0] row_o,
    output logic       col_o,
    output logic       last_o
);
    logic [3:0] row_q, row_d;
    logic       col_q, col_d;
    always_comb begin
        last_o = (row_q == 4'(ROWS - 1)) && col_q;
        col_d  = clear_i ? 1'b0 : advance_i ? ~col_q : col_q;
        row_d  = (clear_i || (advance_i && last_o)) ? 4'd0 :
                 (advance_i && col_q) ? row_q + 4'd1 : row_q;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q <= 4'd0;
            col_q <= 1'b0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end
    assign row_o = row_q;
    assign col_o = col_q;
endmodule

// File: rtl/feature_map_writer.sv
// feature_map_writer: assembles the convolution output map from half-row transfers
module feature_map_writer
    import feature_map_writer_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int H = 8,
    parameter int W = 8,
    parameter int F = 3,
    localparam int OUT_H = out_dim(H, F),
    localparam int OUT_W = out_dim(W, F),
    localparam int HALF = OUT_W / 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [HALF*DATA_WIDTH-1:0]          in_data,
    output logic [3:0]                          rowNumber,
    output logic [3:0]                          column,
    output logic [OUT_H*OUT_W*DATA_WIDTH-1:0]   outputImage,
    output logic                                busy,
    output logic                                frame_done
);
    localparam int IMG_BITS = OUT_H * OUT_W * DATA_WIDTH;
    localparam int LOW = $clog2(IMG_BITS);
    if ((OUT_W % 2) != 0 || OUT_H > 16) begin : g_bad_dims
        $error("feature_map_writer: OUT_W must be even and OUT_H <= 16");
    end
    state_e                state_q, state_d;
    logic                  ready_q, done_q, wr_en, clear, last, col;
    logic [IMG_BITS-1:0]   img_q, img_d;
    logic [LOW-1:0]        lo;
    // start outranks a coincident transfer; start is ignored while DONE
    assign wr_en = in_valid & ready_q & ~start;
    assign clear = start & (state_q != DONE);
    rf_pos_counter #(.ROWS(OUT_H)) u_pos (
        .clk      (clk),
        .rst      (reset),
        .clear_i  (clear),
        .advance_i(wr_en),
        .row_o    (rowNumber),
        .col_o    (col),
        .last_o   (last)
    );
    // Element 0 sits at the MSBs, so the half-row slice is addressed from the top
    always_comb begin
        state_d = (state_q == DONE) ? IDLE : clear ? ACCEPT : (wr_en && last) ? DONE : state_q;
        lo      = LOW'((OUT_H * OUT_W - elem_offset(int'(rowNumber), int'(col), OUT_W) - HALF) * DATA_WIDTH);
        img_d   = img_q;
        if (wr_en) img_d[lo +: HALF*DATA_WIDTH] = in_data;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            img_q   <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_d == ACCEPT);
            done_q  <= (state_d == DONE);
            img_q   <= img_d;
        end
    end
    assign in_ready    = ready_q;
    assign busy        = ready_q;
    assign frame_done  = done_q;
    assign column      = {3'd0, col};
    assign outputImage = img_q;
endmodule

// File: tb/tb_feature_map_writer.sv
// tb_feature_map_writer: randomized self-checking bench against a frame-level model
module tb_feature_map_writer;
    localparam int DW = 16, OH = 6, OW = 6, HALF = 3, NE = OH * OW, NX = OH * 2;
    logic clk = 0, reset = 0, start = 0, in_valid = 0;
    logic [HALF*DW-1:0] in_data = '0;
    logic in_ready, busy, frame_done;
    logic [3:0] rowNumber, column;
    logic [NE*DW-1:0] outputImage;
    int checks = 0, failures = 0;
    logic [DW-1:0] exp_img[NE];
    logic [DW-1:0] saved[NE];
    int n;
    bit m_accept, m_done;
    logic [3:0] tag;

    feature_map_writer #(.DATA_WIDTH(DW), .H(8), .W(8), .F(3)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .rowNumber(rowNumber), .column(column), .outputImage(outputImage),
        .busy(busy), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    function automatic logic [NE*DW-1:0] exp_vec();
        logic [NE*DW-1:0] v;
        for (int e = 0; e < NE; e++) v[(NE-1-e)*DW +: DW] = exp_img[e];
        return v;
    endfunction

    function automatic logic [DW-1:0] img_el(input int e);
        return outputImage[(NE-1-e)*DW +: DW];
    endfunction

    function automatic logic [HALF*DW-1:0] code(input int r, input int c, input logic [3:0] t);
        logic [HALF*DW-1:0] d;
        for (int k = 0; k < HALF; k++) d[(HALF-1-k)*DW +: DW] = {t, 4'(r), 4'(c), 4'(k)};
        return d;
    endfunction

    // Frame-level model: n counts half-rows accepted in the current frame
    task automatic cycle(input bit s, input bit v, input logic [HALF*DW-1:0] d);
        bit was_done, xfer;
        was_done = m_done;
        xfer = m_accept && v && !s;
        start = s; in_valid = v; in_data = d;
        @(posedge clk); #1;
        if (was_done) m_done = 0;
        else if (s) begin m_accept = 1; n = 0; end
        else if (xfer) begin
            for (int k = 0; k < HALF; k++) exp_img[(n/2)*OW + (n%2)*HALF + k] = d[(HALF-1-k)*DW +: DW];
            n++;
            if (n == NX) begin n = 0; m_accept = 0; m_done = 1; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1; start = 0; in_valid = 0;
        @(negedge clk); reset = 0;
        @(posedge clk); #1;
        for (int e = 0; e < NE; e++) exp_img[e] = '0;
        n = 0; m_accept = 0; m_done = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (in_ready !== 0 || busy !== 0 || frame_done !== 0 || rowNumber !== 0 || column !== 0 || outputImage !== '0) begin
            failures++; $display("FAIL reset_init: rdy=%b busy=%b done=%b row=%0d col=%0d img_nonzero=%b", in_ready, busy, frame_done, rowNumber, column, |outputImage);
        end
        cycle(1, 0, '0);
        for (int i = 0; i < 3; i++) cycle(0, 1, {$urandom, $urandom});
        checks++;
        if (outputImage === '0 || rowNumber !== 1 || column !== 1) begin
            failures++; $display("FAIL reset_prefill: row=%0d col=%0d img_nonzero=%b want row=1 col=1 nonzero", rowNumber, column, |outputImage);
        end
        #3 reset = 1; #1;
        checks++;
        if (in_ready !== 0 || busy !== 0 || frame_done !== 0 || rowNumber !== 0 || column !== 0 || outputImage !== '0) begin
            failures++; $display("FAIL reset_async: rdy=%b busy=%b done=%b row=%0d col=%0d img_nonzero=%b want all 0", in_ready, busy, frame_done, rowNumber, column, |outputImage);
        end
        @(negedge clk); reset = 0;
        @(posedge clk); #1;
        for (int e = 0; e < NE; e++) exp_img[e] = '0;
        n = 0; m_accept = 0; m_done = 0;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, {$urandom, $urandom});
            checks++;
            if (frame_done !== 0 || in_ready !== 0) begin
                failures++; $display("FAIL reset_after: done=%b rdy=%b want 0 0", frame_done, in_ready);
            end
        end
    endtask

    task automatic test_full_frame();
        tag = 4'($urandom);
        cycle(1, 0, '0);
        for (int i = 0; i < NX; i++) begin
            checks++;
            if (rowNumber !== 4'(i/2) || column !== 4'(i%2) || in_ready !== 1 || frame_done !== 0) begin
                failures++; $display("FAIL frame_pos%0d: row=%0d col=%0d rdy=%b done=%b want %0d %0d 1 0", i, rowNumber, column, in_ready, frame_done, i/2, i%2);
            end
            cycle(0, 1, code(i/2, i%2, tag));
        end
        checks++;
        if (frame_done !== 1 || in_ready !== 0 || busy !== 0 || rowNumber !== 0 || column !== 0) begin
            failures++; $display("FAIL frame_done: done=%b rdy=%b busy=%b row=%0d col=%0d want 1 0 0 0 0", frame_done, in_ready, busy, rowNumber, column);
        end
        checks++;
        if (outputImage !== exp_vec()) begin
            failures++; $display("FAIL frame_image: got %h want %h", outputImage, exp_vec());
        end
        for (int e = 0; e < NE; e++) saved[e] = exp_img[e];
        cycle(0, 1, '1);
        checks++;
        if (frame_done !== 0 || in_ready !== 0 || outputImage !== exp_vec()) begin
            failures++; $display("FAIL frame_after: done=%b rdy=%b img_ok=%b want 0 0 1", frame_done, in_ready, outputImage === exp_vec());
        end
    endtask

    task automatic test_bubbles();
        int cyc;
        bit v;
        for (int e = 0; e < NE; e++) exp_img[e] = 16'h5A5A;
        cycle(1, 0, '0);
        cyc = 0;
        while (!m_done && cyc < 300) begin
            v = ($urandom_range(0, 2) != 0);
            cycle(0, v, v ? code(n/2, n%2, tag) : {$urandom, $urandom});
            cyc++;
            checks++;
            if (rowNumber !== 4'(n/2) || column !== 4'(n%2) || in_ready !== m_accept || frame_done !== m_done) begin
                failures++; $display("FAIL bubble_pos: row=%0d col=%0d rdy=%b done=%b want %0d %0d %b %b", rowNumber, column, in_ready, frame_done, n/2, n%2, m_accept, m_done);
            end
        end
        checks++;
        if (!m_done) begin
            failures++; $display("FAIL bubble_timeout: frame incomplete after %0d cycles", cyc);
        end
        checks++;
        if (outputImage !== exp_vec()) begin
            failures++; $display("FAIL bubble_image: got %h want %h", outputImage, exp_vec());
        end
        for (int e = 0; e < NE; e++) begin
            checks++;
            if (img_el(e) !== saved[e]) begin
                failures++; $display("FAIL bubble_vs_frame e%0d: got %h want %h", e, img_el(e), saved[e]);
            end
        end
        cycle(0, 0, '0);
    endtask

    task automatic test_ordering();
        logic [HALF*DW-1:0] d1, d2;
        d1 = {$urandom, $urandom};
        d2 = {$urandom, $urandom};
        cycle(1, 0, '0);
        cycle(0, 1, d1);
        cycle(0, 1, d2);
        checks++;
        if (rowNumber !== 1 || column !== 0) begin
            failures++; $display("FAIL order_pos: row=%0d col=%0d want 1 0", rowNumber, column);
        end
        checks++;
        if (img_el(3) !== d2[HALF*DW-1 -: DW] || img_el(0) !== d1[HALF*DW-1 -: DW] || img_el(5) !== d2[DW-1:0]) begin
            failures++; $display("FAIL order_elem: e0=%h e3=%h e5=%h want %h %h %h", img_el(0), img_el(3), img_el(5), d1[HALF*DW-1 -: DW], d2[HALF*DW-1 -: DW], d2[DW-1:0]);
        end
    endtask

    task automatic test_restart();
        logic [3:0] tb_tag;
        tag = 4'($urandom);
        cycle(1, 0, '0);
        for (int i = 0; i < NX; i++) cycle(0, 1, code(i/2, i%2, tag) ^ {$urandom, $urandom});
        cycle(0, 0, '0);
        for (int e = 0; e < NE; e++) saved[e] = exp_img[e];
        tb_tag = ~tag;
        cycle(1, 0, '0);
        for (int i = 0; i < 5; i++) cycle(0, 1, code(i/2, i%2, tb_tag));
        checks++;
        if (rowNumber !== 2 || column !== 1) begin
            failures++; $display("FAIL restart_pre: row=%0d col=%0d want 2 1", rowNumber, column);
        end
        cycle(1, 1, {3{16'hDEAD}});
        checks++;
        if (rowNumber !== 0 || column !== 0 || in_ready !== 1) begin
            failures++; $display("FAIL restart_pos: row=%0d col=%0d rdy=%b want 0 0 1", rowNumber, column, in_ready);
        end
        for (int e = 15; e < NE; e++) begin
            checks++;
            if (img_el(e) !== saved[e]) begin
                failures++; $display("FAIL restart_keep e%0d: got %h want %h", e, img_el(e), saved[e]);
            end
        end
        checks++;
        if (outputImage !== exp_vec()) begin
            failures++; $display("FAIL restart_image: got %h want %h", outputImage, exp_vec());
        end
    endtask

    task automatic test_idle_input();
        for (int i = 0; i < NX; i++) cycle(0, 1, {$urandom, $urandom});
        checks++;
        if (frame_done !== 1) begin
            failures++; $display("FAIL idle_done: done=%b want 1", frame_done);
        end
        cycle(1, 1, '1);
        checks++;
        if (in_ready !== 0 || busy !== 0 || frame_done !== 0 || rowNumber !== 0 || outputImage !== exp_vec()) begin
            failures++; $display("FAIL idle_start_in_done: rdy=%b busy=%b done=%b row=%0d img_ok=%b want 0 0 0 0 1", in_ready, busy, frame_done, rowNumber, outputImage === exp_vec());
        end
        for (int i = 0; i < 4; i++) begin
            cycle(0, 1, '1);
            checks++;
            if (in_ready !== 0 || rowNumber !== 0 || column !== 0 || outputImage !== exp_vec()) begin
                failures++; $display("FAIL idle_input%0d: rdy=%b row=%0d col=%0d img_ok=%b want 0 0 0 1", i, in_ready, rowNumber, column, outputImage === exp_vec());
            end
        end
    endtask

    initial begin
        n = 0; m_accept = 0; m_done = 0;
        for (int e = 0; e < NE; e++) exp_img[e] = '0;
        test_reset();
        test_full_frame();
        test_bubbles();
        test_ordering();
        test_restart();
        test_idle_input();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
